// File: rtl/ahbl_pkg.sv
// Shared encodings for the AHB-Lite memory slave.
// Holds HTRANS/HSIZE/HRESP codes, FSM states and the LFSR seed.
package ahbl_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HALF  = 3'd1;
  localparam logic [2:0] SZ_WORD  = 3'd2;
  localparam logic [2:0] SZ_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/ahbl_lfsr16.sv
// Random wait-state source: 16-bit Galois LFSR, one step per accepted transfer.
// Only built when AHBL_SLAVE_MEM_RANDWAIT_EN is defined.
`ifdef AHBL_SLAVE_MEM_RANDWAIT_EN
module ahbl_lfsr16
  import ahbl_pkg::*;
#(
  parameter int WAITS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  output logic [3:0] wait_n
);

  logic [15:0] lfsr;

  // Step the LFSR once for every accepted address phase
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (adv) begin
      lfsr <= {1'b0, lfsr[15:1]}
            ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign wait_n = 4'(32'(lfsr[3:0]) % (WAITS + 1));

endmodule
`endif

// File: rtl/ahbl_slave_mem.sv
// AHB-Lite memory slave with fixed wait states and an error window.
// Define AHBL_SLAVE_MEM_RANDWAIT_EN for LFSR-driven random wait states.
module ahbl_slave_mem
  import ahbl_pkg::*;
#(
  parameter int          AWIDTH   = 12,
  parameter int          DWIDTH   = 32,
  parameter int          WAITS    = 0,
  parameter logic [31:0] ERR_BASE = 32'hF00,
  parameter logic [31:0] ERR_SIZE = 32'h100
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic              HWRITE,
  input  logic              HMASTLOCK,
  input  logic [AWIDTH-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [DWIDTH-1:0] HWDATA,
  output logic [DWIDTH-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int NB    = DWIDTH / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int IW    = AWIDTH - OFFW;
  localparam int DEPTH = 2 ** IW;

  logic [DWIDTH-1:0] mem [DEPTH];

  state_e            state;
  logic [3:0]        cnt;
  logic              dp_q;
  logic              wr_q;
  logic [AWIDTH-1:0] addr_q;
  logic [2:0]        size_q;
  logic              ready_q;
  logic              resp_q;

  logic              acc;
  logic              bad;
  logic              done;
  logic              wr_en;
  logic [3:0]        wnum;
  logic [NB-1:0]     lane;
  logic [IW-1:0]     idx_q;
  logic              unused_in;

  assign unused_in = ^{HBURST, HPROT, HMASTLOCK};

  assign acc = HSEL & HREADY & ready_q
             & ((HTRANS == TR_NONSEQ) | (HTRANS == TR_SEQ));

  // Classify the address phase: error window, oversize, misaligned
  always_comb begin
    logic [31:0] a32;
    logic [3:0]  amask;
    logic        in_win;
    logic        sz_bad;
    logic        mis;
    a32    = 32'(HADDR);
    amask  = (4'b0001 << HSIZE) - 4'd1;
    in_win = (ERR_SIZE != 32'd0)
           && (a32 >= ERR_BASE)
           && (a32 < (ERR_BASE + ERR_SIZE));
    sz_bad = HSIZE > 3'(OFFW);
    mis    = |(a32[3:0] & amask);
    bad    = in_win | sz_bad | mis;
  end

`ifdef AHBL_SLAVE_MEM_RANDWAIT_EN
  ahbl_lfsr16 #(
    .WAITS (WAITS)
  ) u_lfsr (
    .clk    (HCLK),
    .rst    (HRESET),
    .adv    (acc),
    .wait_n (wnum)
  );
`else
  assign wnum = 4'(WAITS);
`endif

  assign idx_q = addr_q[AWIDTH-1:OFFW];
  assign done  = dp_q & (state == S_IDLE);
  assign wr_en = done & wr_q & ~HRESET;

  // Transfer sequencing; registered HREADYOUT/HRESP
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      dp_q    <= 1'b0;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
    end else begin
      unique case (state)
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state   <= S_ERR2;
          ready_q <= 1'b1;
          resp_q  <= HRESP_ERROR;
        end
        S_IDLE, S_ERR2: begin
          state   <= S_IDLE;
          dp_q    <= 1'b0;
          ready_q <= 1'b1;
          resp_q  <= HRESP_OKAY;
          if (acc) begin
            addr_q <= HADDR;
            wr_q   <= HWRITE;
            size_q <= HSIZE;
            if (bad) begin
              state   <= S_ERR1;
              ready_q <= 1'b0;
              resp_q  <= HRESP_ERROR;
            end else begin
              dp_q <= 1'b1;
              if (wnum != 4'd0) begin
                state   <= S_WAIT;
                ready_q <= 1'b0;
                cnt     <= wnum - 4'd1;
              end
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
          resp_q  <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Byte lanes covered by the registered size and offset
  always_comb begin
    lane = '0;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(addr_q[OFFW-1:0])
          && i < int'(addr_q[OFFW-1:0]) + (1 << size_q))
        lane[i] = 1'b1;
    end
  end

  // Storage update on write completion, per byte lane
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_en && lane[i])
        mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
    end
  end

  // Read data only in a read completion cycle
  always_comb begin
    HRDATA = '0;
    if (done && !wr_q && !HRESET)
      HRDATA = mem[idx_q];
  end

  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;

endmodule

// File: tb/tb_ahbl_slave_mem.sv
// Directed bench for ahbl_slave_mem: one WAITS=0 and one WAITS=3 instance.
// Each scenario task checks its own expected values inline.
module tb_ahbl_slave_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel0 = 1'b0;
  logic        sel3 = 1'b0;
  logic [11:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'b0011;
  logic        hlock = 1'b0;
  logic [31:0] hwdata = '0;

  logic        rdy0, rdy3, rsp0, rsp3;
  logic [31:0] rd0, rd3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ahbl_slave_mem #(.WAITS(0)) u0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HREADY(rdy0),
    .HWRITE(hwrite), .HMASTLOCK(hlock), .HADDR(haddr),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HWDATA(hwdata), .HRDATA(rd0),
    .HREADYOUT(rdy0), .HRESP(rsp0)
  );

  ahbl_slave_mem #(.WAITS(3)) u3 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel3), .HREADY(rdy3),
    .HWRITE(hwrite), .HMASTLOCK(hlock), .HADDR(haddr),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HWDATA(hwdata), .HRDATA(rd3),
    .HREADYOUT(rdy3), .HRESP(rsp3)
  );

  task automatic xfer(input bit d3, input bit wr,
                      input logic [11:0] a, input logic [2:0] sz,
                      input logic [31:0] wd,
                      output logic [31:0] rd, output logic err,
                      output int lows, output logic lowresp);
    sel0   = ~d3;
    sel3   = d3;
    haddr  = a;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    @(posedge clk); #1;
    sel0   = 1'b0;
    sel3   = 1'b0;
    htrans = 2'b00;
    hwdata = wd;
    lows    = 0;
    lowresp = 1'b0;
    while (!(d3 ? rdy3 : rdy0) && lows < 20) begin
      if (lows == 0) lowresp = d3 ? rsp3 : rsp0;
      lows++;
      @(posedge clk); #1;
    end
    if (lows >= 20) begin
      errors++;
      $display("FAIL timeout addr=%h: HREADYOUT stuck low", a);
    end
    rd  = d3 ? rd3 : rd0;
    err = d3 ? rsp3 : rsp0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++; $display("FAIL reset_rdy0 got=%b exp=1", rdy0);
    end
    checks++;
    if (rsp0 !== 1'b0) begin
      errors++; $display("FAIL reset_rsp0 got=%b exp=0", rsp0);
    end
    checks++;
    if (rd0 !== 32'h0) begin
      errors++; $display("FAIL reset_rd0 got=%h exp=0", rd0);
    end
    checks++;
    if (rdy3 !== 1'b1) begin
      errors++; $display("FAIL reset_rdy3 got=%b exp=1", rdy3);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; logic e, lr; int lw;
    xfer(0, 1, 12'h010, 3'd2, 32'hDEADBEEF, rd, e, lw, lr);
    checks++;
    if (lw !== 0 || e !== 1'b0) begin
      errors++; $display("FAIL word_wr lows=%0d err=%b exp 0/0", lw, e);
    end
    xfer(0, 0, 12'h010, 3'd2, 32'h0, rd, e, lw, lr);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_rd got=%h exp=deadbeef", rd);
    end
    checks++;
    if (lw !== 0 || e !== 1'b0) begin
      errors++; $display("FAIL word_rd_wait lows=%0d err=%b exp 0/0", lw, e);
    end
  endtask

  task automatic test_waits();
    logic [31:0] rd; logic e, lr; int lw;
    xfer(1, 1, 12'h020, 3'd2, 32'hA5A50F0F, rd, e, lw, lr);
    checks++;
    if (lw !== 3) begin
      errors++; $display("FAIL wait_wr lows=%0d exp=3", lw);
    end
    xfer(1, 0, 12'h020, 3'd2, 32'h0, rd, e, lw, lr);
    checks++;
    if (lw !== 3 || e !== 1'b0) begin
      errors++; $display("FAIL wait_rd lows=%0d err=%b exp 3/0", lw, e);
    end
    checks++;
    if (rd !== 32'hA5A50F0F) begin
      errors++; $display("FAIL wait_rd_data got=%h exp=a5a50f0f", rd);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic e, lr; int lw;
    xfer(0, 1, 12'h010, 3'd2, 32'h11223344, rd, e, lw, lr);
    xfer(0, 1, 12'h013, 3'd0, 32'h5A000000, rd, e, lw, lr);
    checks++;
    if (e !== 1'b0) begin
      errors++; $display("FAIL byte_wr_resp got=%b exp=0", e);
    end
    xfer(0, 0, 12'h010, 3'd2, 32'h0, rd, e, lw, lr);
    checks++;
    if (rd !== 32'h5A223344) begin
      errors++; $display("FAIL byte_rd got=%h exp=5a223344", rd);
    end
    xfer(0, 1, 12'h012, 3'd1, 32'hBEEF0000, rd, e, lw, lr);
    xfer(0, 0, 12'h010, 3'd2, 32'h0, rd, e, lw, lr);
    checks++;
    if (rd !== 32'hBEEF3344) begin
      errors++; $display("FAIL half_rd got=%h exp=beef3344", rd);
    end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic e, lr; int lw;
    xfer(0, 1, 12'hF04, 3'd2, 32'h0BADF00D, rd, e, lw, lr);
    checks++;
    if (lw !== 1 || lr !== 1'b1 || e !== 1'b1) begin
      errors++;
      $display("FAIL err_wr lows=%0d r1=%b r2=%b exp 1/1/1", lw, lr, e);
    end
    xfer(0, 0, 12'hF04, 3'd2, 32'h0, rd, e, lw, lr);
    checks++;
    if (lw !== 1 || lr !== 1'b1 || e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_rd lows=%0d r1=%b r2=%b rd=%h exp 1/1/1/0",
               lw, lr, e, rd);
    end
    xfer(0, 0, 12'hFFC, 3'd2, 32'h0, rd, e, lw, lr);
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL err_top got=%b exp=1", e);
    end
    xfer(0, 1, 12'hEFC, 3'd2, 32'h76543210, rd, e, lw, lr);
    xfer(0, 0, 12'hEFC, 3'd2, 32'h0, rd, e, lw, lr);
    checks++;
    if (e !== 1'b0 || lw !== 0 || rd !== 32'h76543210) begin
      errors++;
      $display("FAIL below_win err=%b lows=%0d rd=%h exp 0/0/76543210",
               e, lw, rd);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic e, lr; int lw;
    xfer(0, 1, 12'h011, 3'd1, 32'hFFFFFFFF, rd, e, lw, lr);
    checks++;
    if (lw !== 1 || e !== 1'b1) begin
      errors++; $display("FAIL mis_half lows=%0d err=%b exp 1/1", lw, e);
    end
    xfer(0, 0, 12'h010, 3'd3, 32'h0, rd, e, lw, lr);
    checks++;
    if (e !== 1'b1) begin
      errors++; $display("FAIL oversize err=%b exp=1", e);
    end
    xfer(0, 0, 12'h010, 3'd2, 32'h0, rd, e, lw, lr);
    checks++;
    if (rd !== 32'hBEEF3344) begin
      errors++; $display("FAIL mis_nowrite got=%h exp=beef3344", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e, lr; int lw;
    sel0   = 1'b1;
    haddr  = 12'h000;
    htrans = 2'b10;
    hwrite = 1'b1;
    hsize  = 3'd2;
    @(posedge clk); #1;
    hwdata = 32'h01020304;
    haddr  = 12'h004;
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++; $display("FAIL b2b_first rdy=%b exp=1", rdy0);
    end
    @(posedge clk); #1;
    hwdata = 32'hA0B0C0D0;
    sel0   = 1'b0;
    htrans = 2'b00;
    checks++;
    if (rdy0 !== 1'b1 || rsp0 !== 1'b0) begin
      errors++; $display("FAIL b2b_second rdy=%b rsp=%b exp 1/0", rdy0, rsp0);
    end
    @(posedge clk); #1;
    xfer(0, 0, 12'h000, 3'd2, 32'h0, rd, e, lw, lr);
    checks++;
    if (rd !== 32'h01020304) begin
      errors++; $display("FAIL b2b_rd0 got=%h exp=01020304", rd);
    end
    xfer(0, 0, 12'h004, 3'd2, 32'h0, rd, e, lw, lr);
    checks++;
    if (rd !== 32'hA0B0C0D0) begin
      errors++; $display("FAIL b2b_rd4 got=%h exp=a0b0c0d0", rd);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic e, lr; int lw;
    xfer(1, 1, 12'h030, 3'd2, 32'hCAFEF00D, rd, e, lw, lr);
    sel3   = 1'b1;
    haddr  = 12'h030;
    htrans = 2'b10;
    hwrite = 1'b1;
    hsize  = 3'd2;
    @(posedge clk); #1;
    sel3   = 1'b0;
    htrans = 2'b00;
    hwdata = 32'h12345678;
    checks++;
    if (rdy3 !== 1'b0) begin
      errors++; $display("FAIL rst_wait_entry rdy=%b exp=0", rdy3);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rdy3 !== 1'b1 || rsp3 !== 1'b0 || rd3 !== 32'h0) begin
      errors++;
      $display("FAIL rst_wait rdy=%b rsp=%b rd=%h exp 1/0/0",
               rdy3, rsp3, rd3);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(1, 0, 12'h030, 3'd2, 32'h0, rd, e, lw, lr);
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rst_nowrite got=%h exp=cafef00d", rd);
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_waits();
    test_byte_lanes();
    test_error();
    test_misalign();
    test_back_to_back();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
